user_mem_ctrl: RTL and testbench

Command sequencer in front of the per-user height/weight store: 32 users × 12-bit height and 32 users × 12-bit weight, with synchronous write and combinational read.
- Accepts host commands over a valid/ready handshake: read user, write height, write weight, scan-all.
- Drives the store's write enables, index and write data.
- Returns read data, or a total weight across all users, over a valid/ready response channel.
- Only master of the store; serialises all accesses.

---
 rtl/user_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_user_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/user_mem_ctrl.sv
// Command sequencer in front of the per-user height/weight store: serialises host reads, writes and
// full-store weight scans. Optional define USER_MEM_ACTIVE_COUNT_EN adds a nonzero-weight user count to scan responses.
module user_mem_ctrl #(
   parameter int NUM_USERS = 32,
   parameter int IDX_W     = 5,
   parameter int DATA_W    = 12,
   parameter int SUM_W     = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_index,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_height,
   output logic [DATA_W-1:0] rsp_weight,
   output logic [SUM_W-1:0]  rsp_sum,
   output logic [IDX_W:0]    rsp_count,
   output logic              busy,
   output logic              mem_we_height,
   output logic              mem_we_weight,
   output logic [IDX_W-1:0]  mem_user_index,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_height_out,
   input  logic [DATA_W-1:0] mem_weight_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_SCAN,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WR_H  = 2'b01;
   localparam logic [1:0] OP_WR_W  = 2'b10;
   localparam logic [1:0] OP_SCAN  = 2'b11;

   state_t              r_state;
   state_t              w_state_next;
   logic [1:0]          r_op;
   logic [IDX_W-1:0]    r_index;
   logic [DATA_W-1:0]   r_data;
   logic [IDX_W-1:0]    r_scan_idx;
   logic [SUM_W-1:0]    r_acc;
   logic [DATA_W-1:0]   r_rsp_height;
   logic [DATA_W-1:0]   r_rsp_weight;
   logic [SUM_W-1:0]    r_rsp_sum;
   logic                w_accept;
   logic                w_scan_last;
   logic [SUM_W-1:0]    w_acc_next;

   assign w_accept    = cmd_valid & cmd_ready;
   assign w_scan_last = (r_scan_idx == IDX_W'(NUM_USERS - 1));
   assign w_acc_next  = r_acc + SUM_W'(mem_weight_out);

   // cmd_ready is gated by rst so nothing is accepted while reset is held.
   assign cmd_ready  = (r_state == S_IDLE) & ~rst;
   assign busy       = (r_state != S_IDLE);
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_height = r_rsp_height;
   assign rsp_weight = r_rsp_weight;
   assign rsp_sum    = r_rsp_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_READ: w_state_next = S_READ;
                  OP_SCAN: w_state_next = S_SCAN;
                  default: w_state_next = S_WRITE;
               endcase
            end
         end
         S_WRITE: w_state_next = S_IDLE;
         S_READ:  w_state_next = S_RESP;
         S_SCAN: begin
            if (w_scan_last) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Store-side drive is purely a function of state, so reset forces every enable low at once.
   always_comb begin
      mem_we_height  = 1'b0;
      mem_we_weight  = 1'b0;
      mem_user_index = '0;
      mem_data_in    = '0;
      case (r_state)
         S_WRITE: begin
            mem_we_height  = (r_op == OP_WR_H);
            mem_we_weight  = (r_op == OP_WR_W);
            mem_user_index = r_index;
            mem_data_in    = r_data;
         end
         S_READ: begin
            mem_user_index = r_index;
         end
         S_SCAN: begin
            mem_user_index = r_scan_idx;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= '0;
         r_index      <= '0;
         r_data       <= '0;
         r_scan_idx   <= '0;
         r_acc        <= '0;
         r_rsp_height <= '0;
         r_rsp_weight <= '0;
         r_rsp_sum    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op       <= cmd_op;
                  r_index    <= cmd_index;
                  r_data     <= cmd_data;
                  r_scan_idx <= '0;
                  r_acc      <= '0;
               end
            end
            S_READ: begin
               r_rsp_height <= mem_height_out;
               r_rsp_weight <= mem_weight_out;
               r_rsp_sum    <= '0;
            end
            S_SCAN: begin
               r_acc <= w_acc_next;
               if (w_scan_last) begin
                  r_rsp_sum    <= w_acc_next;
                  r_rsp_height <= '0;
                  r_rsp_weight <= '0;
               end else begin
                  r_scan_idx <= r_scan_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef USER_MEM_ACTIVE_COUNT_EN
   logic [IDX_W:0] r_cnt;
   logic [IDX_W:0] r_rsp_count;
   logic [IDX_W:0] w_cnt_next;

   assign w_cnt_next = r_cnt + {{IDX_W{1'b0}}, (mem_weight_out != '0)};
   assign rsp_count  = r_rsp_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rsp_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
               end
            end
            S_READ: begin
               r_rsp_count <= '0;
            end
            S_SCAN: begin
               r_cnt <= w_cnt_next;
               if (w_scan_last) begin
                  r_rsp_count <= w_cnt_next;
               end
            end
            default: begin
            end
         endcase
      end
   end
`else
   assign rsp_count = '0;
`endif

endmodule

// File: tb/tb_user_mem_ctrl.sv
// Directed bench for user_mem_ctrl with a behavioural height/weight store model.
// Expected values are hand-computed; rsp_count expectations follow USER_MEM_ACTIVE_COUNT_EN.
module tb_user_mem_ctrl;
   localparam int IDX_W  = 5;
   localparam int DATA_W = 12;
   localparam int SUM_W  = 17;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [IDX_W-1:0]  cmd_index;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_height;
   logic [DATA_W-1:0] rsp_weight;
   logic [SUM_W-1:0]  rsp_sum;
   logic [IDX_W:0]    rsp_count;
   logic              busy;
   logic              mem_we_height;
   logic              mem_we_weight;
   logic [IDX_W-1:0]  mem_user_index;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_height_out;
   logic [DATA_W-1:0] mem_weight_out;

   logic [DATA_W-1:0] st_h [32] = '{default: '0};
   logic [DATA_W-1:0] st_w [32] = '{default: '0};

   int checks = 0;
   int errors = 0;

   user_mem_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_index(cmd_index), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_height(rsp_height), .rsp_weight(rsp_weight),
      .rsp_sum(rsp_sum), .rsp_count(rsp_count), .busy(busy),
      .mem_we_height(mem_we_height), .mem_we_weight(mem_we_weight),
      .mem_user_index(mem_user_index), .mem_data_in(mem_data_in),
      .mem_height_out(mem_height_out), .mem_weight_out(mem_weight_out)
   );

   always #5 clk = ~clk;

   assign mem_height_out = st_h[mem_user_index];
   assign mem_weight_out = st_w[mem_user_index];

   always @(posedge clk) begin
      if (mem_we_height) st_h[mem_user_index] <= mem_data_in;
      if (mem_we_weight) st_w[mem_user_index] <= mem_data_in;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int c);
`ifdef USER_MEM_ACTIVE_COUNT_EN
      return 32'(c);
`else
      return 32'(c * 0);
`endif
   endfunction

   // Called at a negedge; returns at a negedge with the controller idle again.
   task automatic do_write(input logic [1:0] op, input int idx, input logic [11:0] data);
      cmd_valid = 1'b1; cmd_op = op; cmd_index = 5'(idx); cmd_data = data;
      check("wr_ready_before", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("wr_we_h", 32'(mem_we_height), 32'(op == 2'b01));
      check("wr_we_w", 32'(mem_we_weight), 32'(op == 2'b10));
      check("wr_idx", 32'(mem_user_index), 32'(idx));
      check("wr_data", 32'(mem_data_in), 32'(data));
      check("wr_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("wr_we_off", 32'({mem_we_height, mem_we_weight}), 32'd0);
      check("wr_data_off", 32'(mem_data_in), 32'd0);
      check("wr_ready_back", 32'(cmd_ready), 32'd1);
      $display("write op=%0d user=%0d data=%03h", op, idx, data);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("rsp_arrives", 32'(rsp_valid), 32'd1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
      check("rsp_idle_ready", 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_read(input int idx, input logic [11:0] eh, input logic [11:0] ew);
      int n;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_index = 5'(idx); cmd_data = '0;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_rsp(n);
      check("rd_latency", 32'(n), 32'd1);
      check("rd_height", 32'(rsp_height), 32'(eh));
      check("rd_weight", 32'(rsp_weight), 32'(ew));
      check("rd_sum", 32'(rsp_sum), 32'd0);
      check("rd_count", 32'(rsp_count), 32'd0);
      $display("read user=%0d height=%03h weight=%03h", idx, rsp_height, rsp_weight);
      take_rsp();
   endtask

   task automatic do_scan(input int esum, input int ecnt, input bit hold);
      int n;
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_index = 5'd7; cmd_data = 12'h5A5;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("scan_busy", 32'(busy), 32'd1);
      wait_rsp(n);
      check("scan_cycles", 32'(n), 32'd32);
      check("scan_sum", 32'(rsp_sum), 32'(esum));
      check("scan_height", 32'(rsp_height), 32'd0);
      check("scan_weight", 32'(rsp_weight), 32'd0);
      check("scan_count", 32'(rsp_count), exp_cnt(ecnt));
      $display("scan sum=%0d count=%0d cycles=%0d", rsp_sum, rsp_count, n);
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_sum", 32'(rsp_sum), 32'(esum));
            check("hold_count", 32'(rsp_count), exp_cnt(ecnt));
            check("hold_ready", 32'(cmd_ready), 32'd0);
         end
      end
      take_rsp();
   endtask

   initial begin
      int k;
      int wi;
      int last_acc;
      int n;
      logic prev_we;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_data = '0; rsp_ready = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_we", 32'({mem_we_height, mem_we_weight}), 32'd0);
      check("rst_sum", 32'(rsp_sum), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);

      do_write(2'b01, 3, 12'h0AB);
      do_write(2'b10, 3, 12'h064);
      do_read(3, 12'h0AB, 12'h064);

      // Back-to-back weight writes with cmd_valid held high.
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 12'hFFF;
      k = 0; wi = 0; last_acc = 0; prev_we = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         check("b2b_no_consec", 32'(prev_we & mem_we_weight), 32'd0);
         check("b2b_no_height", 32'(mem_we_height), 32'd0);
         if (mem_we_weight) begin
            check("b2b_idx", 32'(mem_user_index), 32'(wi));
            wi++;
         end
         prev_we = mem_we_weight;
         if (cmd_ready) begin
            if (k == 32) begin
               cmd_valid = 1'b0;
               break;
            end
            cmd_index = 5'(k);
            if (k > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd2);
            last_acc = cyc;
            k++;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", 32'(k), 32'd32);
      check("b2b_writes", 32'(wi), 32'd32);
      $display("back-to-back writes accepted=%0d enables=%0d", k, wi);

      do_scan(131040, 32, 1'b0);

      for (int u = 1; u < 31; u++) do_write(2'b10, u, 12'h000);
      do_write(2'b10, 0, 12'h00A);
      do_write(2'b10, 31, 12'h00A);
      do_scan(20, 2, 1'b1);

      // Reset in the middle of a scan.
      cmd_valid = 1'b1; cmd_op = 2'b11;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (mem_user_index != 5'd15 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("mid_scan_idx", 32'(mem_user_index), 32'd15);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd0);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      check("abort_idx", 32'(mem_user_index), 32'd0);
      check("abort_sum", 32'(rsp_sum), 32'd0);
      check("abort_count", 32'(rsp_count), 32'd0);
      $display("reset asserted during scan at index 15");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_recover", 32'(cmd_ready), 32'd1);
      do_scan(20, 2, 1'b0);

      rsp_ready = 1'b1;
      @(negedge clk);
      check("idle_rsp_ready_ignored", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b0;
      do_read(3, 12'h0AB, 12'h000);
      do_read(31, 12'h000, 12'h00A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
